// File: rtl/sd_srv_pkg.sv
// Shared types and block geometry for the virtual-disk block server.
package sd_srv_pkg;

  localparam int         BLK_BYTES = 512;
  localparam int         BLK_SHIFT = 9;
  localparam logic [8:0] LAST_BYTE = 9'(BLK_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_ADDR,
    S_WR_CAP,
    S_WR_WAIT,
    S_FILL,
    S_DONE
  } state_t;

endpackage

// File: rtl/sd_srv_img_table.sv
// Per-drive image table (base, size, read-only) plus the mount strobes.
module sd_srv_img_table
  import sd_srv_pkg::*;
#(
  parameter int VDNUM  = 3,
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_drv,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [23:0]       cfg_blocks,
  input  logic              cfg_ro,
  input  logic [1:0]        sel,
  output logic [ADDR_W-1:0] sel_base,
  output logic [23:0]       sel_blocks,
  output logic              sel_ro,
  output logic [VDNUM-1:0]  img_mounted,
  output logic [63:0]       img_size,
  output logic              img_readonly
);

  logic [ADDR_W-1:0] base_q   [VDNUM];
  logic [23:0]       blocks_q [VDNUM];
  logic [VDNUM-1:0]  ro_q;
  logic              drv_ok;

  // Writes to drive slots that do not exist are dropped entirely.
  assign drv_ok = cfg_wr && ({30'b0, cfg_drv} < 32'(VDNUM));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < VDNUM; d++) begin
        base_q[d]   <= '0;
        blocks_q[d] <= '0;
      end
      ro_q         <= '0;
      img_mounted  <= '0;
      img_size     <= '0;
      img_readonly <= 1'b0;
    end else begin
      img_mounted <= '0;
      if (drv_ok) begin
        img_size     <= 64'({cfg_blocks, {BLK_SHIFT{1'b0}}});
        img_readonly <= cfg_ro;
      end
      for (int d = 0; d < VDNUM; d++) begin
        if (drv_ok && cfg_drv == 2'(d)) begin
          base_q[d]      <= cfg_base;
          blocks_q[d]    <= cfg_blocks;
          ro_q[d]        <= cfg_ro;
          img_mounted[d] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_base   = '0;
    sel_blocks = '0;
    sel_ro     = 1'b0;
    for (int d = 0; d < VDNUM; d++) begin
      if (sel == 2'(d)) begin
        sel_base   = base_q[d];
        sel_blocks = blocks_q[d];
        sel_ro     = ro_q[d];
      end
    end
  end

endmodule

// File: rtl/sd_block_server.sv
// Responder side of the sd_* block protocol: arbitrates drive requests and
// moves 512-byte blocks between the requester's buffer and backing memory.
module sd_block_server
  import sd_srv_pkg::*;
#(
  parameter int VDNUM  = 3,
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic [VDNUM-1:0]  sd_rd,
  input  logic [VDNUM-1:0]  sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_drv,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [23:0]       cfg_blocks,
  input  logic              cfg_ro,
  output logic [VDNUM-1:0]  img_mounted,
  output logic [63:0]       img_size,
  output logic              img_readonly,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready
);

  state_t            state, state_nx;
  logic [8:0]        idx;
  logic [ADDR_W-1:0] start_q;
  logic              wr_ok_q;
  logic [7:0]        byte_q;
  logic [8:0]        baddr_q;
  logic [7:0]        bdout_q;
  logic              bwr_q;

  logic              req_any, win_rd, lba_ok, last;
  logic [1:0]        win;
  logic [ADDR_W-1:0] sel_base, win_start;
  logic [23:0]       sel_blocks;
  logic              sel_ro;

  sd_srv_img_table #(.VDNUM(VDNUM), .ADDR_W(ADDR_W)) u_table (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .cfg_wr       (cfg_wr),
    .cfg_drv      (cfg_drv),
    .cfg_base     (cfg_base),
    .cfg_blocks   (cfg_blocks),
    .cfg_ro       (cfg_ro),
    .sel          (win),
    .sel_base     (sel_base),
    .sel_blocks   (sel_blocks),
    .sel_ro       (sel_ro),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_readonly (img_readonly)
  );

  // Descending scan so the lowest requesting drive is the one left standing.
  always_comb begin
    win    = '0;
    win_rd = 1'b0;
    for (int d = VDNUM - 1; d >= 0; d--) begin
      if (sd_rd[d] || sd_wr[d]) begin
        win    = 2'(d);
        win_rd = sd_rd[d];
      end
    end
    req_any = |{sd_rd, sd_wr};
  end

  assign lba_ok    = (sel_blocks != '0) && (sd_lba < 32'(sel_blocks));
  assign win_start = sel_base + ADDR_W'({sd_lba, {BLK_SHIFT{1'b0}}});
  assign last      = (idx == LAST_BYTE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (req_any) state_nx = win_rd ? (lba_ok ? S_RD_REQ : S_FILL) : S_WR_ADDR;
      S_RD_REQ:  state_nx = S_RD_WAIT;
      S_RD_WAIT: if (mem_ready) state_nx = last ? S_DONE : S_RD_REQ;
      S_FILL:    state_nx = last ? S_DONE : S_FILL;
      S_WR_ADDR: state_nx = S_WR_CAP;
      S_WR_CAP:  state_nx = wr_ok_q ? S_WR_WAIT : (last ? S_DONE : S_WR_ADDR);
      S_WR_WAIT: if (mem_ready) state_nx = last ? S_DONE : S_WR_ADDR;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      start_q <= '0;
      wr_ok_q <= 1'b0;
      byte_q  <= '0;
      baddr_q <= '0;
      bdout_q <= '0;
      bwr_q   <= 1'b0;
    end else begin
      state <= state_nx;
      bwr_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          idx <= '0;
          if (req_any) begin
            start_q <= win_start;
            wr_ok_q <= lba_ok && !sel_ro;
          end
        end
        S_RD_WAIT: if (mem_ready) begin
          bwr_q   <= 1'b1;
          baddr_q <= idx;
          bdout_q <= mem_dout;
          idx     <= idx + 9'd1;
        end
        S_FILL: begin
          bwr_q   <= 1'b1;
          baddr_q <= idx;
          bdout_q <= '0;
          idx     <= idx + 9'd1;
        end
        S_WR_CAP: begin
          byte_q <= sd_buff_din;
          if (!wr_ok_q) idx <= idx + 9'd1;
        end
        S_WR_WAIT: if (mem_ready) idx <= idx + 9'd1;
        default: ;
      endcase
    end
  end

  // Handshake outputs decode straight from state so reset drops them at once.
  assign sd_ack       = (state != S_IDLE) && (state != S_DONE);
  assign mem_rd       = (state == S_RD_REQ) || (state == S_RD_WAIT);
  assign mem_wr       = (state == S_WR_WAIT);
  assign mem_addr     = (mem_rd || mem_wr) ? start_q + ADDR_W'(idx) : '0;
  assign mem_din      = mem_wr ? byte_q : '0;
  assign sd_buff_addr = (state == S_WR_ADDR || state == S_WR_CAP || state == S_WR_WAIT) ? idx : baddr_q;
  assign sd_buff_dout = bdout_q;
  assign sd_buff_wr   = bwr_q;

endmodule

// File: tb/tb_sd_block_server.sv
// Directed/randomized bench for sd_block_server with a byte-level reference model.
module tb_sd_block_server;

  localparam int VDNUM  = 3;
  localparam int ADDR_W = 25;

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic [31:0]       sd_lba  = '0;
  logic [VDNUM-1:0]  sd_rd   = '0;
  logic [VDNUM-1:0]  sd_wr   = '0;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din = '0;
  logic              cfg_wr     = 1'b0;
  logic [1:0]        cfg_drv    = '0;
  logic [ADDR_W-1:0] cfg_base   = '0;
  logic [23:0]       cfg_blocks = '0;
  logic              cfg_ro     = 1'b0;
  logic [VDNUM-1:0]  img_mounted;
  logic [63:0]       img_size;
  logic              img_readonly;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout  = '0;
  logic              mem_ready = 1'b0;

  sd_block_server #(.VDNUM(VDNUM), .ADDR_W(ADDR_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .cfg_wr(cfg_wr), .cfg_drv(cfg_drv),
    .cfg_base(cfg_base), .cfg_blocks(cfg_blocks), .cfg_ro(cfg_ro), .img_mounted(img_mounted),
    .img_size(img_size), .img_readonly(img_readonly), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors = 0, miscompares = 0;
  int lat_max = 3;

  logic [7:0] mem [longint];
  logic [7:0] src [512];
  longint     m_base [VDNUM], m_blocks [VDNUM];
  bit         m_ro [VDNUM];

  longint log_mrd[$], log_mwr[$], log_bw[$];
  longint exp_mrd[$], exp_mwr[$], exp_bw[$];
  int     ack_falls = 0, both_cnt = 0;

  bit         busy = 0, prev_ack = 0;
  int         cnt = 0;
  logic [7:0] rdata = '0;
  logic [8:0] prev_a = '0;

  function automatic logic [7:0] mem_model(input longint a);
    if (mem.exists(a)) return mem[a];
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Protocol monitor, sector-buffer dpram and latency-randomized backing memory.
  always @(negedge clk_sys) begin
    longint a;
    if (reset) begin
      busy = 0; mem_ready = 1'b0; cnt = 0; prev_ack = 0;
    end else begin
      if (sd_buff_wr) log_bw.push_back(longint'(sd_buff_addr) * 256 + longint'(sd_buff_dout));
      if (mem_rd && mem_wr) both_cnt++;
      if (prev_ack && !sd_ack) ack_falls++;
      prev_ack = sd_ack;
      sd_buff_din = src[prev_a];
      prev_a = sd_buff_addr;
      if (mem_ready) begin
        mem_ready = 1'b0; busy = 0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin mem_ready = 1'b1; mem_dout = rdata; end
      end
      if (!busy && !mem_ready && (mem_rd || mem_wr)) begin
        busy = 1;
        cnt = int'($urandom_range(lat_max, 1));
        a = longint'(mem_addr);
        if (mem_rd) begin
          log_mrd.push_back(a);
          rdata = mem_model(a);
        end else begin
          log_mwr.push_back(a * 256 + longint'(mem_din));
          mem[a] = mem_din;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] drv, input longint base, input longint blocks, input bit ro);
    logic [VDNUM-1:0] exp_mnt;
    logic [63:0]      exp_size;
    bit               exp_ro;
    exp_size = img_size;
    exp_ro   = img_readonly;
    @(negedge clk_sys);
    cfg_drv = drv; cfg_base = base[ADDR_W-1:0]; cfg_blocks = blocks[23:0]; cfg_ro = ro; cfg_wr = 1'b1;
    @(negedge clk_sys);
    cfg_wr = 1'b0;
    exp_mnt = '0;
    if (int'(drv) < VDNUM) begin
      m_base[drv] = base; m_blocks[drv] = blocks; m_ro[drv] = ro;
      exp_mnt[drv] = 1'b1;
      exp_size = 64'(blocks * 512);
      exp_ro = ro;
    end
    check("img_mounted", 64'(img_mounted), 64'(exp_mnt));
    check("img_size", img_size, exp_size);
    check("img_readonly", 64'(img_readonly), 64'(exp_ro));
    @(negedge clk_sys);
    check("img_mounted_pulse_end", 64'(img_mounted), 64'd0);
  endtask

  // Expected traffic of one transfer, straight from block geometry and table contents.
  task automatic model_xfer(input int d, input bit is_rd, input logic [31:0] lba);
    longint st, a;
    bit     valid;
    st = (m_base[d] + longint'(lba) * 512) & 64'h1FF_FFFF;
    valid = (m_blocks[d] != 0) && (longint'(lba) < m_blocks[d]);
    for (int i = 0; i < 512; i++) begin
      a = (st + i) & 64'h1FF_FFFF;
      if (is_rd) begin
        if (valid) begin
          exp_mrd.push_back(a);
          exp_bw.push_back(longint'(i) * 256 + longint'(mem_model(a)));
        end else begin
          exp_bw.push_back(longint'(i) * 256);
        end
      end else if (valid && !m_ro[d]) begin
        exp_mwr.push_back(a * 256 + longint'(src[i]));
      end
    end
  endtask

  task automatic cmp_q(input string tag, input longint got[$], input longint exp[$]);
    int bad;
    bad = 0;
    check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (got[i] != exp[i]) bad++;
    check({tag, "_content"}, 64'(bad), 64'd0);
  endtask

  task automatic run_req(input logic [VDNUM-1:0] rd, input logic [VDNUM-1:0] wr,
                         input logic [31:0] lba, input int nx);
    logic [VDNUM-1:0] r, w;
    int d, cyc;
    bit is_rd;
    log_mrd.delete(); log_mwr.delete(); log_bw.delete();
    exp_mrd.delete(); exp_mwr.delete(); exp_bw.delete();
    ack_falls = 0;
    r = rd; w = wr;
    @(negedge clk_sys);
    sd_lba = lba; sd_rd = r; sd_wr = w;
    for (int t = 0; t < nx; t++) begin
      cyc = 0;
      while (sd_ack !== 1'b1 && cyc < 200) begin @(negedge clk_sys); cyc++; end
      check("ack_rise", 64'(sd_ack), 64'd1);
      d = 0;
      while (d < VDNUM - 1 && !(r[d] || w[d])) d++;
      is_rd = r[d];
      if (is_rd) r[d] = 1'b0; else w[d] = 1'b0;
      sd_rd = r; sd_wr = w;
      model_xfer(d, is_rd, lba);
      cyc = 0;
      while (sd_ack !== 1'b0 && cyc < 40000) begin @(negedge clk_sys); cyc++; end
      check("ack_fall", 64'(sd_ack), 64'd0);
    end
    repeat (3) @(negedge clk_sys);
    check("ack_pulses", 64'(ack_falls), 64'(nx));
    check("rd_wr_overlap", 64'(both_cnt), 64'd0);
    cmp_q("mem_rd", log_mrd, exp_mrd);
    cmp_q("mem_wr", log_mwr, exp_mwr);
    cmp_q("buff_wr", log_bw, exp_bw);
  endtask

  task automatic shuffle_src();
    for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] wsrc [512];
    int bad, cyc;
    for (int d = 0; d < VDNUM; d++) begin m_base[d] = 0; m_blocks[d] = 0; m_ro[d] = 0; end
    shuffle_src();
    repeat (3) @(negedge clk_sys);
    check("rst_sd_ack", 64'(sd_ack), 64'd0);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_buff_wr", 64'(sd_buff_wr), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_img_mounted", 64'(img_mounted), 64'd0);
    check("rst_img_size", img_size, 64'd0);
    check("rst_img_readonly", 64'(img_readonly), 64'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // In-range read on drive 0, then the first out-of-range block.
    cfg(2'd0, 64'h10000, 4, 1'b0);
    run_req(3'b001, 3'b000, 32'd2, 1);
    check("blk2_first_addr", 64'(log_mrd.size() > 0 ? log_mrd[0] : -1), 64'h10400);
    run_req(3'b001, 3'b000, 32'd4, 1);

    // Read-only drive: buffer drained, memory untouched.
    cfg(2'd1, 64'h20000, 8, 1'b1);
    shuffle_src();
    run_req(3'b000, 3'b010, 32'd3, 1);

    // Two drives at once: lowest index first.
    run_req(3'b011, 3'b000, 32'd1, 2);
    check("arb_first_is_drv0", 64'(log_mrd.size() > 0 ? log_mrd[0] : -1), 64'h10200);

    // Round trip with long random latency; start address wraps the memory space.
    cfg(2'd2, 64'h1FF_FF00, 16, 1'b0);
    lat_max = 20;
    shuffle_src();
    for (int i = 0; i < 512; i++) wsrc[i] = src[i];
    run_req(3'b000, 3'b100, 32'd5, 1);
    shuffle_src();
    run_req(3'b100, 3'b000, 32'd5, 1);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (i >= log_bw.size() || log_bw[i] != longint'(i) * 256 + longint'(wsrc[i])) bad++;
    check("roundtrip", 64'(bad), 64'd0);
    lat_max = 3;

    // Read and write on the same drive: read goes first.
    shuffle_src();
    run_req(3'b100, 3'b100, 32'd5, 2);

    // Nonexistent drive slot, then unmount drive 0.
    cfg(2'd3, 64'h5000, 9, 1'b1);
    cfg(2'd0, 64'h10000, 0, 1'b0);
    run_req(3'b001, 3'b000, 32'd0, 1);

    // Reset in the middle of a read.
    cfg(2'd0, 64'h10000, 4, 1'b0);
    log_bw.delete();
    @(negedge clk_sys);
    sd_lba = 32'd1; sd_rd = 3'b001;
    cyc = 0;
    while (log_bw.size() < 100 && cyc < 5000) begin @(negedge clk_sys); cyc++; end
    check("reached_byte_100", 64'(log_bw.size() >= 100), 64'd1);
    reset = 1'b1; sd_rd = '0;
    #1;
    check("midrst_sd_ack", 64'(sd_ack), 64'd0);
    check("midrst_mem_rd", 64'(mem_rd), 64'd0);
    check("midrst_buff_wr", 64'(sd_buff_wr), 64'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    check("midrst_img_size", img_size, 64'd0);
    check("midrst_img_readonly", 64'(img_readonly), 64'd0);
    for (int d = 0; d < VDNUM; d++) begin m_base[d] = 0; m_blocks[d] = 0; m_ro[d] = 0; end
    both_cnt = 0;
    run_req(3'b001, 3'b000, 32'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
